// File: rtl/vram_arbiter.sv
// Display RAM arbiter: video character fetch has absolute priority with a fixed
// 2-cycle read latency; the CPU gets the remaining cycles via req/ack.
module vram_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int WAIT_CNT_W   = 8
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_starved,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_ISSUED = 2'd1,
    C_DATA   = 2'd2
  } cpu_state_t;

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = {WAIT_CNT_W{1'b1}};
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

  cpu_state_t            cpu_state_r;
  logic                  cpu_we_r;
  logic                  vid_pend_r;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic [WAIT_CNT_W-1:0] wait_nxt_s;
  logic                  cpu_gnt_s;

  // RAM port grant: video first, CPU only when its FSM is idle; writes gated by reset
  always_comb begin
    cpu_gnt_s = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vid_req) begin
      ram_addr = vid_addr;
    end else if ((cpu_state_r == C_IDLE) && cpu_req) begin
      cpu_gnt_s = 1'b1;
      ram_addr  = cpu_addr;
      ram_we    = cpu_we & reset_n;
      ram_wdata = cpu_wdata;
    end else begin
      ram_addr = '0;
    end
  end

  // Next value of the saturating CPU wait counter
  always_comb begin
    wait_nxt_s = wait_cnt_r;
    if (cpu_gnt_s || !cpu_req) begin
      wait_nxt_s = '0;
    end else if (cpu_state_r == C_IDLE) begin
      wait_nxt_s = (wait_cnt_r == WAIT_MAX) ? wait_cnt_r : wait_cnt_r + WAIT_ONE;
    end else begin
      wait_nxt_s = wait_cnt_r;
    end
  end

  // Video tag pipeline: the RAM word arriving one cycle after a fetch is registered out
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      vid_pend_r <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
    end else begin
      vid_pend_r <= vid_req;
      vid_valid  <= vid_pend_r;
      if (vid_pend_r) begin
        vid_data <= ram_rdata;
      end
    end
  end

  // Starvation monitor: sticky once the wait count reaches the limit
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r  <= '0;
      cpu_starved <= 1'b0;
    end else begin
      wait_cnt_r <= wait_nxt_s;
      if (wait_nxt_s >= WAIT_LIMIT) begin
        cpu_starved <= 1'b1;
      end
    end
  end

  // CPU access FSM; write ack is raised at the grant edge so it shows one cycle later
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cpu_state_r <= C_IDLE;
      cpu_we_r    <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (cpu_state_r)
        C_IDLE: begin
          if (cpu_gnt_s) begin
            cpu_we_r    <= cpu_we;
            cpu_ack     <= cpu_we;
            cpu_state_r <= C_ISSUED;
          end
        end
        C_ISSUED: begin
          if (cpu_we_r) begin
            cpu_state_r <= C_IDLE;
          end else begin
            cpu_rdata   <= ram_rdata;
            cpu_ack     <= 1'b1;
            cpu_state_r <= C_DATA;
          end
        end
        C_DATA: begin
          cpu_state_r <= C_IDLE;
        end
        default: begin
          cpu_state_r <= C_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 2K x 8 synchronous RAM.
module tb_vram_arbiter;

  logic        clk_pixel;
  logic        reset_n;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_starved;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:2047];
  logic [7:0]  ref_mem [0:2047];
  logic        preload;
  int          n_checks;
  int          n_errors;

  vram_arbiter dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_starved (cpu_starved),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  function automatic logic [7:0] init_val(input int i);
    logic [10:0] a;
    a = 11'(i);
    return (a == 11'h123) ? 8'h41 : (a[7:0] ^ 8'hA5);
  endfunction

  // Synchronous single-port RAM, read-before-write
  always @(posedge clk_pixel) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_pixel);
  endtask

  initial begin
    logic       busy, op_we, vp0, vp1, vp2;
    logic [10:0] op_addr;
    logic [7:0] op_wdata, vd0, vd1, vd2;
    int         op_cnt, n_acks, bad;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    reset_n = 1'b0; preload = 1'b1;
    vid_req = 1'b0; vid_addr = 11'h000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h055; cpu_wdata = 8'hFF;

    // reset state, write enable must stay low while in reset
    repeat (2) @(posedge clk_pixel);
    sample();
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_vid_valid", vid_valid, 0);
    check_eq("rst_vid_data", vid_data, 0);
    check_eq("rst_cpu_ack", cpu_ack, 0);
    check_eq("rst_cpu_rdata", cpu_rdata, 0);
    check_eq("rst_starved", cpu_starved, 0);
    cpu_req = 1'b0; cpu_we = 1'b0; preload = 1'b0;
    next_cycle();
    reset_n = 1'b1;

    // video read of 0x123
    next_cycle(); vid_req = 1'b1; vid_addr = 11'h123;
    sample(); check_eq("v_ram_addr", ram_addr, 11'h123); check_eq("v_ram_we", ram_we, 0);
    next_cycle(); vid_req = 1'b0;
    sample(); check_eq("v_valid_t1", vid_valid, 0);
    next_cycle();
    sample(); check_eq("v_valid_t2", vid_valid, 1); check_eq("v_data_t2", vid_data, 8'h41);
    next_cycle();
    sample(); check_eq("v_valid_t3", vid_valid, 0);

    // CPU write then read of 0x7FF
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_wdata = 8'h5A;
    sample(); check_eq("w_ram_we", ram_we, 1); check_eq("w_ram_addr", ram_addr, 11'h7FF);
    check_eq("w_ram_wdata", ram_wdata, 8'h5A); check_eq("w_ack_t0", cpu_ack, 0);
    next_cycle();
    sample(); check_eq("w_ack_t1", cpu_ack, 1); check_eq("w_no_regrant", ram_we, 0);
    ref_mem[11'h7FF] = 8'h5A;
    next_cycle(); cpu_we = 1'b0;
    sample(); check_eq("r_ram_addr", ram_addr, 11'h7FF); check_eq("r_ack_t0", cpu_ack, 0);
    check_eq("w_mem", mem[11'h7FF], 8'h5A);
    next_cycle();
    sample(); check_eq("r_ack_t1", cpu_ack, 0);
    next_cycle();
    sample(); check_eq("r_ack_t2", cpu_ack, 1); check_eq("r_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;

    // collision: video wins, CPU served in the next free cycle
    next_cycle(); vid_req = 1'b1; vid_addr = 11'h1AB; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    sample(); check_eq("c_ram_addr_vid", ram_addr, 11'h1AB); check_eq("c_ram_we", ram_we, 0);
    next_cycle(); vid_req = 1'b0;
    sample(); check_eq("c_ram_addr_cpu", ram_addr, 11'h7FF);
    next_cycle();
    sample(); check_eq("c_vid_valid", vid_valid, 1); check_eq("c_vid_data", vid_data, 8'h0E);
    check_eq("c_ack_early", cpu_ack, 0);
    next_cycle();
    sample(); check_eq("c_ack", cpu_ack, 1); check_eq("c_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;

    // starvation: video holds the port for 20 cycles
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      vid_req = 1'b1; vid_addr = 11'h123;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'h33;
      sample();
      if (k == 15) check_eq("s_not_yet", cpu_starved, 0);
      if (k == 16) check_eq("s_starved", cpu_starved, 1);
      if (k == 19) check_eq("s_no_grant", ram_we, 0);
    end
    next_cycle(); vid_req = 1'b0;
    sample(); check_eq("s_grant_we", ram_we, 1); check_eq("s_grant_addr", ram_addr, 11'h010);
    next_cycle();
    sample(); check_eq("s_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    ref_mem[11'h010] = 8'h33;
    repeat (3) next_cycle();
    sample(); check_eq("s_sticky", cpu_starved, 1);

    // async reset in the middle of a CPU read with a video fetch in flight
    next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF;
    next_cycle(); vid_req = 1'b1; vid_addr = 11'h123;
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar_vid_valid", vid_valid, 0);
    check_eq("ar_vid_data", vid_data, 0);
    check_eq("ar_cpu_rdata", cpu_rdata, 0);
    check_eq("ar_cpu_ack", cpu_ack, 0);
    check_eq("ar_starved", cpu_starved, 0);
    vid_req = 1'b0; cpu_req = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      if (cpu_ack !== 1'b0 || vid_valid !== 1'b0) bad++;
      next_cycle();
    end
    check_eq("ar_no_ack_after", bad, 0);

    // text timing: video every 8 cycles with random CPU traffic in 0x000-0x0FF
    busy = 1'b0; op_we = 1'b0; op_addr = '0; op_wdata = '0; op_cnt = 0; n_acks = 0;
    vp0 = 1'b0; vp1 = 1'b0; vp2 = 1'b0; vd0 = '0; vd1 = '0; vd2 = '0;
    for (int c = 0; c < 480; c++) begin
      next_cycle();
      vid_req  = ((c % 8) == 0) && (c < 440);
      vid_addr = 11'h100 | 11'((c * 7) & 255);
      vp2 = vp1; vd2 = vd1; vp1 = vp0; vd1 = vd0;
      vp0 = vid_req; vd0 = ref_mem[vid_addr];
      if (!busy && c < 440 && $urandom_range(0, 1) == 1) begin
        busy = 1'b1; op_cnt = 0;
        op_we = 1'($urandom_range(0, 1));
        op_addr = 11'($urandom_range(0, 255));
        op_wdata = 8'($urandom_range(0, 255));
        cpu_req = 1'b1; cpu_we = op_we; cpu_addr = op_addr; cpu_wdata = op_wdata;
      end
      sample();
      check_eq("t_vid_valid", vid_valid, vp2);
      if (vp2) check_eq("t_vid_data", vid_data, vd2);
      if (busy) begin
        op_cnt++;
        if (cpu_ack) begin
          n_acks++;
          if (op_we) ref_mem[op_addr] = op_wdata;
          else check_eq("t_cpu_rdata", cpu_rdata, ref_mem[op_addr]);
          busy = 1'b0; cpu_req = 1'b0;
        end else if (op_cnt > 40) begin
          check_eq("t_ack_timeout", op_cnt, 0);
          busy = 1'b0; cpu_req = 1'b0;
        end
      end else begin
        check_eq("t_spurious_ack", cpu_ack, 0);
      end
    end
    check_eq("t_all_done", busy, 0);
    check_eq("t_some_acks", (n_acks > 20), 1);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_eq("t_ram_contents", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
